// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, replacement policy codes and address field helpers for the icache
package icache_pkg;

    typedef enum logic {IDLE, REFILL} state_t;

    localparam int REPL_RR   = 0;
    localparam int REPL_PLRU = 1;

    // Address layout: tag | index | offset | 2-bit byte
    function automatic logic [63:0] get_offset(input logic [63:0] addr, input int off_bits);
        return (addr >> 2) & ((64'd1 << off_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] get_index(input logic [63:0] addr, input int off_bits,
                                              input int idx_bits);
        return (addr >> (2 + off_bits)) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] get_tag(input logic [63:0] addr, input int off_bits,
                                            input int idx_bits);
        return addr >> (2 + off_bits + idx_bits);
    endfunction

endpackage

// File: rtl/icache_plru_tree.sv
// rtl/icache_plru_tree.sv - tree pseudo-LRU victim select and update for one set
module icache_plru_tree
    import icache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int WAY_W    = 2,
    parameter int PLRU_W   = 3
) (
    input  logic [PLRU_W-1:0] tree_bits,
    input  logic [WAY_W-1:0]  access_way,
    output logic [WAY_W-1:0]  victim,
    output logic [PLRU_W-1:0] next_bits
);
    localparam int LEVELS = $clog2(NUM_WAYS);

    // Heap-ordered nodes: children of n are 2n+1 (left) and 2n+2 (right); a bit points at the LRU side
    always_comb begin
        int node;
        victim = '0;
        node   = 0;
        for (int l = 0; l < LEVELS; l++) begin
            victim[LEVELS-1-l] = tree_bits[node];
            node = 2 * node + 1 + int'(tree_bits[node]);
        end
    end

    always_comb begin
        int node;
        next_bits = tree_bits;
        node      = 0;
        for (int l = 0; l < LEVELS; l++) begin
            next_bits[node] = ~access_way[LEVELS-1-l];
            node = 2 * node + 1 + int'(access_way[LEVELS-1-l]);
        end
    end

endmodule

// File: rtl/icache_cwf_plru.sv
// rtl/icache_cwf_plru.sv - set-associative icache with CWF refill and early restart; ICACHE_PERF_CNT_EN adds hit/miss counters
module icache_cwf_plru
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WAYS    = 4,
    parameter int NUM_SETS    = 64,
    parameter int LINE_WORDS  = 4,
    parameter int REPL_POLICY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_req,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_valid,
    output logic                  cpu_stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_valid,
    input  logic                  invalidate,
    output logic [31:0]           perf_hits,
    output logic [31:0]           perf_misses
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
    localparam int POLICY = (NUM_WAYS == 1) ? REPL_RR : REPL_POLICY;

    logic [DATA_WIDTH-1:0] data_ram [NUM_WAYS][NUM_SETS][LINE_WORDS];
    logic [TAG_W-1:0]      tag_ram  [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0]   valid    [NUM_SETS];
    logic [WAY_W-1:0]      rr_cnt   [NUM_SETS];
    logic [PLRU_W-1:0]     plru     [NUM_SETS];

    state_t                state;
    logic [TAG_W-1:0]      req_tag, r_tag;
    logic [IDX_W-1:0]      req_idx, r_idx;
    logic [OFF_W-1:0]      req_off, r_crit, r_count, beat_off;
    logic [WAY_W-1:0]      r_way, hit_way, victim, tree_victim, tree_way;
    logic [PLRU_W-1:0]     tree_bits, tree_next;
    logic [NUM_WAYS-1:0]   hit_vec;
    logic [LINE_WORDS-1:0] r_wvalid;
    logic                  hit, line_match, beat_match, last_beat, miss_start;

    assign req_off = OFF_W'(get_offset(64'(cpu_addr), OFF_W));
    assign req_idx = IDX_W'(get_index(64'(cpu_addr), OFF_W, IDX_W));
    assign req_tag = TAG_W'(get_tag(64'(cpu_addr), OFF_W, IDX_W));

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid[req_idx][w] && (tag_ram[w][req_idx] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
        hit = |hit_vec;
    end

    // Invalid ways are filled lowest-first before the policy gets a say
    always_comb begin
        victim = (POLICY == REPL_PLRU) ? tree_victim : rr_cnt[req_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[req_idx][w]) victim = WAY_W'(w);
        end
    end

    assign tree_bits = (state == REFILL) ? plru[r_idx] : plru[req_idx];
    assign tree_way  = (state == REFILL) ? r_way : hit_way;

    icache_plru_tree #(
        .NUM_WAYS(NUM_WAYS),
        .WAY_W   (WAY_W),
        .PLRU_W  (PLRU_W)
    ) u_tree (
        .tree_bits (tree_bits),
        .access_way(tree_way),
        .victim    (tree_victim),
        .next_bits (tree_next)
    );

    assign beat_off   = r_crit + r_count;
    assign line_match = (req_tag == r_tag) && (req_idx == r_idx);
    assign beat_match = mem_valid && (beat_off == req_off);
    assign last_beat  = mem_valid && (r_count == OFF_W'(LINE_WORDS - 1));

    always_comb begin
        cpu_valid  = 1'b0;
        cpu_data   = '0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        miss_start = 1'b0;
        if (state == IDLE) begin
            if (cpu_req) begin
                if (hit) begin
                    cpu_valid = 1'b1;
                    cpu_data  = data_ram[hit_way][req_idx][req_off];
                end else begin
                    mem_req    = 1'b1;
                    mem_addr   = cpu_addr;
                    miss_start = 1'b1;
                end
            end
        end else begin
            mem_req  = 1'b1;
            mem_addr = {r_tag, r_idx, beat_off, 2'b00};
            if (cpu_req && line_match) begin
                if (beat_match) begin
                    cpu_valid = 1'b1;
                    cpu_data  = mem_data;
                end else if (r_wvalid[req_off]) begin
                    cpu_valid = 1'b1;
                    cpu_data  = data_ram[r_way][r_idx][req_off];
                end
            end
        end
        cpu_stall = cpu_req && !cpu_valid;
    end

    always_ff @(posedge clk) begin
        if (rst || invalidate) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s]  <= '0;
                rr_cnt[s] <= '0;
                plru[s]   <= '0;
            end
            state    <= IDLE;
            r_count  <= '0;
            r_wvalid <= '0;
        end else if (state == IDLE) begin
            if (cpu_req && hit && POLICY == REPL_PLRU) plru[req_idx] <= tree_next;
            if (miss_start) begin
                r_tag    <= req_tag;
                r_idx    <= req_idx;
                r_crit   <= req_off;
                r_way    <= victim;
                r_count  <= '0;
                r_wvalid <= '0;
                state    <= REFILL;
            end
        end else if (mem_valid) begin
            r_wvalid[beat_off] <= 1'b1;
            r_count            <= r_count + OFF_W'(1);
            if (last_beat) begin
                valid[r_idx][r_way] <= 1'b1;
                if (POLICY == REPL_PLRU) plru[r_idx] <= tree_next;
                else rr_cnt[r_idx] <= (rr_cnt[r_idx] == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                              : rr_cnt[r_idx] + WAY_W'(1);
                state <= IDLE;
            end
        end
    end

    // Line storage is not reset; a line only becomes visible through its valid bit
    always_ff @(posedge clk) begin
        if (state == REFILL && mem_valid) begin
            data_ram[r_way][r_idx][beat_off] <= mem_data;
            if (last_beat) tag_ram[r_way][r_idx] <= r_tag;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;

    always_ff @(posedge clk) begin
        if (rst || invalidate) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (cpu_valid)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss_start) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign perf_hits   = hit_cnt;
    assign perf_misses = miss_cnt;
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule
